// File: rtl/alu_exec_ctrl.sv
// alu_exec_ctrl
// Operand-supply and result-writeback controller wrapped around an external
// 4-bit combinational ALU. It owns a small register bank and a flag register,
// accepts one operation at a time over valid/ready, presents registered
// operands to the ALU, captures its result and flags, and writes them back
// through a three-state sequence IDLE -> EXEC -> WB.
module alu_exec_ctrl #(
  parameter int W    = 4,  // data width, tied to the ALU width
  parameter int NREG = 4   // register count, addressed by 2-bit fields
) (
  input  logic         clk,
  input  logic         rst_n,

  // Operation request
  input  logic         op_valid,
  output logic         op_ready,
  input  logic [1:0]   op_code,
  input  logic         op_l,
  input  logic [1:0]   op_rs,
  input  logic [1:0]   op_rt,
  input  logic [1:0]   op_rd,
  input  logic         op_we,

  // Direct register load
  input  logic         load_valid,
  input  logic [1:0]   load_addr,
  input  logic [W-1:0] load_data,

  // ALU interface
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  output logic [1:0]   alu_op,
  output logic         alu_l,
  input  logic [W-1:0] alu_r,
  input  logic         alu_zero,
  input  logic         alu_carry,
  input  logic         alu_sign,

  // Status
  output logic [2:0]   flags,
  output logic         done,

  // Debug read port
  input  logic [1:0]   dbg_addr,
  output logic [W-1:0] dbg_data
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  // Per-cycle actions decoded from the current state and requests
  logic load_en;   // direct load into the bank this edge
  logic accept;    // operation accepted this edge
  logic cap_en;    // capture ALU outputs this edge
  logic wb_en;     // commit result and flags this edge

  // Register bank and pipeline holding registers
  logic [W-1:0] regs [NREG];
  logic [1:0]   rd_q;     // destination of the operation in flight
  logic         we_q;     // write enable of the operation in flight
  logic [W-1:0] res;      // captured ALU result
  logic [2:0]   fres;     // captured {sign, carry, zero}

  // Handshake and status outputs are pure functions of state and requests.
  assign op_ready = (state == IDLE) && !load_valid;
  assign done     = (state == WB);
  assign dbg_data = regs[dbg_addr];

  // State register.
  // NOTE: every clocked block uses non-blocking (<=) assignments so all
  // registers sample the pre-edge values and no read/write ordering race
  // exists between blocks.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and action decode; a load in IDLE always beats an operation.
  // NOTE: every signal written here gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    load_en    = 1'b0;
    accept     = 1'b0;
    cap_en     = 1'b0;
    wb_en      = 1'b0;
    case (state)
      IDLE: begin
        if (load_valid) begin
          load_en = 1'b1;
        end else if (op_valid) begin
          accept     = 1'b1;
          state_next = EXEC;
        end
      end
      EXEC: begin
        cap_en     = 1'b1;
        state_next = WB;
      end
      WB: begin
        wb_en      = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Register bank: direct loads in IDLE, result writeback in WB. The two
  // enables come from different states and can never be active together.
  // NOTE: the bank is small and its contents are architecturally visible
  // through dbg_data, so it is cleared on reset like any other register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else if (load_en) begin
      regs[load_addr] <= load_data;
    end else if (wb_en && we_q) begin
      regs[rd_q] <= res;
    end
  end

  // ALU operand and control registers: loaded only on accept and held
  // stable through EXEC and WB so the ALU sees a steady input.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      alu_a  <= '0;
      alu_b  <= '0;
      alu_op <= '0;
      alu_l  <= 1'b0;
    end else if (accept) begin
      alu_a  <= regs[op_rs];
      alu_b  <= regs[op_rt];
      alu_op <= op_code;
      alu_l  <= op_l;
    end
  end

  // Destination and write-enable of the operation in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_q <= '0;
      we_q <= 1'b0;
    end else if (accept) begin
      rd_q <= op_rd;
      we_q <= op_we;
    end
  end

  // Capture ALU result and flags at the end of EXEC; stored unmodified.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      res  <= '0;
      fres <= '0;
    end else if (cap_en) begin
      res  <= alu_r;
      fres <= {alu_sign, alu_carry, alu_zero};
    end
  end

  // Flag register: updated at the end of every WB, whether or not the
  // result itself is written back.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      flags <= '0;
    end else if (wb_en) begin
      flags <= fres;
    end
  end

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// tb_alu_exec_ctrl
// Scoreboard bench for alu_exec_ctrl. A behavioural ALU sits on the DUT's
// ALU port; a reference register bank in the bench predicts every result,
// the stimulus process pushes predictions, and a monitor pops and compares
// whenever done is presented.
module tb_alu_exec_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       op_valid = 1'b0;
  logic       op_ready;
  logic [1:0] op_code = '0;
  logic       op_l = 1'b0;
  logic [1:0] op_rs = '0;
  logic [1:0] op_rt = '0;
  logic [1:0] op_rd = '0;
  logic       op_we = 1'b0;
  logic       load_valid = 1'b0;
  logic [1:0] load_addr = '0;
  logic [3:0] load_data = '0;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [1:0] alu_op;
  logic       alu_l;
  logic [3:0] alu_r;
  logic       alu_zero;
  logic       alu_carry;
  logic       alu_sign;
  logic [2:0] flags;
  logic       done;
  logic [1:0] dbg_addr;
  logic [3:0] dbg_data;

  // Debug address is shared: the monitor takes it while checking a writeback.
  logic [1:0] stim_dbg = '0;
  logic [1:0] mon_dbg = '0;
  logic       mon_active = 1'b0;
  assign dbg_addr = mon_active ? mon_dbg : stim_dbg;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int done_cnt = 0;
  int last_acc = 0;

  typedef struct {
    logic [1:0] rd;
    logic       we;
    logic [3:0] a;
    logic [3:0] b;
    logic [1:0] op;
    logic       l;
    logic [3:0] exp_reg;
    logic [2:0] f;
    int         acc;
  } exp_t;

  exp_t       sb[$];
  logic [3:0] mreg [4];

  // Behavioural ALU: returns {sign, carry, zero, r}. Add/sub report the sign
  // of the true signed result; logic ops report the MSB.
  function automatic logic [6:0] alu_model(input logic [3:0] a, input logic [3:0] b,
                                           input logic [1:0] op, input logic l);
    logic [4:0] s;
    logic [3:0] r;
    logic       c;
    logic       sg;
    int         sa;
    int         sbv;
    s   = '0;
    sa  = int'($signed(a));
    sbv = int'($signed(b));
    case (op)
      2'd0: begin
        s  = {1'b0, a} + {1'b0, b};
        r  = s[3:0];
        c  = s[4];
        sg = (sa + sbv) < 0;
      end
      2'd1: begin
        s  = {1'b0, a} + {1'b0, ~b} + 5'd1;
        r  = s[3:0];
        c  = s[4];
        sg = (sa - sbv) < 0;
      end
      2'd2: begin
        r  = l ? ~(a & b) : (a & b);
        c  = 1'b0;
        sg = r[3];
      end
      default: begin
        r  = l ? ~(a ^ b) : (a ^ b);
        c  = 1'b0;
        sg = r[3];
      end
    endcase
    return {sg, c, (r == 4'd0), r};
  endfunction

  assign {alu_sign, alu_carry, alu_zero, alu_r} = alu_model(alu_a, alu_b, alu_op, alu_l);

  alu_exec_ctrl #(.W(4), .NREG(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .op_valid   (op_valid),
    .op_ready   (op_ready),
    .op_code    (op_code),
    .op_l       (op_l),
    .op_rs      (op_rs),
    .op_rt      (op_rt),
    .op_rd      (op_rd),
    .op_we      (op_we),
    .load_valid (load_valid),
    .load_addr  (load_addr),
    .load_data  (load_data),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_l      (alu_l),
    .alu_r      (alu_r),
    .alu_zero   (alu_zero),
    .alu_carry  (alu_carry),
    .alu_sign   (alu_sign),
    .flags      (flags),
    .done       (done),
    .dbg_addr   (dbg_addr),
    .dbg_data   (dbg_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: on each done pulse pop the oldest prediction, check latency and
  // held ALU inputs, then check the committed register and flags.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        done_cnt++;
        if (sb.size() == 0) begin
          check("unexpected_done", done, 0);
        end else begin
          e = sb.pop_front();
          check("done_latency", cyc - e.acc, 1);
          check("wb_ready_low", op_ready, 0);
          check("hold_alu_a", alu_a, e.a);
          check("hold_alu_b", alu_b, e.b);
          check("hold_alu_op", alu_op, e.op);
          check("hold_alu_l", alu_l, e.l);
          @(negedge clk);
          mon_dbg    = e.rd;
          mon_active = 1'b1;
          #1;
          check("wb_reg", dbg_data, e.exp_reg);
          check("wb_flags", flags, e.f);
          check("done_one_cycle", done, 0);
          mon_active = 1'b0;
        end
      end
    end
  end

  task automatic apply_reset();
    @(negedge clk);
    rst_n      = 1'b0;
    op_valid   = 1'b0;
    load_valid = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) mreg[i] = '0;
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic check_reset_state();
    for (int i = 0; i < 4; i++) begin
      stim_dbg = 2'(i);
      #1;
      check("rst_reg", dbg_data, 0);
    end
    check("rst_flags", flags, 0);
    check("rst_done", done, 0);
    check("rst_ready", op_ready, 1);
    check("rst_alu_a", alu_a, 0);
    check("rst_alu_b", alu_b, 0);
    check("rst_alu_op", alu_op, 0);
  endtask

  // Wait until no operation is in flight and the monitor has finished.
  task automatic drain();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      #1;
      if (sb.size() == 0 && op_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("drain_timeout", sb.size(), 0);
    @(negedge clk);
    #2;
  endtask

  // Direct load; caller guarantees the DUT is idle.
  task automatic do_load(input logic [1:0] addr, input logic [3:0] data);
    @(negedge clk);
    load_valid = 1'b1;
    load_addr  = addr;
    load_data  = data;
    #1;
    check("load_blocks_ready", op_ready, 0);
    @(posedge clk);
    mreg[addr] = data;
    #1;
    load_valid = 1'b0;
    stim_dbg   = addr;
    #1;
    check("load_dbg", dbg_data, data);
  endtask

  // Present an operation, wait for acceptance, predict and push its outcome.
  // keep leaves op_valid high for a following op; spur drives a load during
  // EXEC, which must be ignored.
  task automatic issue_op(input logic [1:0] code, input logic l, input logic [1:0] rs,
                          input logic [1:0] rt, input logic [1:0] rd, input logic we,
                          input bit keep, input bit spur);
    exp_t       e;
    logic [6:0] m;
    bit         ok;
    @(negedge clk);
    op_valid = 1'b1;
    op_code  = code;
    op_l     = l;
    op_rs    = rs;
    op_rt    = rt;
    op_rd    = rd;
    op_we    = we;
    #1;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (op_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
      #1;
    end
    if (!ok) begin
      check("accept_timeout", op_ready, 1);
      op_valid = 1'b0;
      return;
    end
    @(posedge clk);
    m         = alu_model(mreg[rs], mreg[rt], code, l);
    e.rd      = rd;
    e.we      = we;
    e.a       = mreg[rs];
    e.b       = mreg[rt];
    e.op      = code;
    e.l       = l;
    e.f       = m[6:4];
    if (we) mreg[rd] = m[3:0];
    e.exp_reg = mreg[rd];
    #1;
    e.acc    = cyc;
    last_acc = cyc;
    sb.push_back(e);
    check("acc_alu_a", alu_a, e.a);
    check("acc_alu_b", alu_b, e.b);
    check("acc_alu_op", alu_op, e.op);
    check("acc_alu_l", alu_l, e.l);
    check("exec_ready_low", op_ready, 0);
    if (!keep) op_valid = 1'b0;
    if (spur && !keep) begin
      @(negedge clk);
      load_valid = 1'b1;
      load_addr  = 2'($urandom);
      load_data  = 4'($urandom);
      @(negedge clk);
      load_valid = 1'b0;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int         a1;
    int         a2;
    int         d0;
    int         k;
    int         coll;
    logic [1:0] r_rs;
    logic [1:0] r_rt;
    logic [1:0] r_rd;
    logic [1:0] r_op;

    for (int i = 0; i < 4; i++) mreg[i] = '0;

    // Reset state
    apply_reset();
    check_reset_state();

    // Basic op: R3 = R1 + R2 = 3 + 5
    do_load(2'd1, 4'd3);
    do_load(2'd2, 4'd5);
    issue_op(2'd0, 1'b0, 2'd1, 2'd2, 2'd3, 1'b1, 1'b0, 1'b0);
    check("basic_alu_a", alu_a, 3);
    check("basic_alu_b", alu_b, 5);
    drain();
    stim_dbg = 2'd3;
    #1;
    check("basic_r3", dbg_data, 8);
    check("basic_flags", flags, 3'b000);

    // Flags without write: 3 - 3 gives zero and carry, R1 untouched
    issue_op(2'd1, 1'b0, 2'd1, 2'd1, 2'd1, 1'b0, 1'b0, 1'b0);
    drain();
    stim_dbg = 2'd1;
    #1;
    check("nowe_r1", dbg_data, 3);
    check("nowe_flags", flags, 3'b011);

    // Load/op collision: load wins, op accepted on the next edge
    @(negedge clk);
    load_valid = 1'b1;
    load_addr  = 2'd0;
    load_data  = 4'd9;
    op_valid   = 1'b1;
    op_code    = 2'd0;
    op_l       = 1'b0;
    op_rs      = 2'd0;
    op_rt      = 2'd0;
    op_rd      = 2'd2;
    op_we      = 1'b1;
    #1;
    check("collide_ready", op_ready, 0);
    @(posedge clk);
    mreg[0] = 4'd9;
    #1;
    coll       = cyc;
    load_valid = 1'b0;
    stim_dbg   = 2'd0;
    #1;
    check("collide_r0", dbg_data, 9);
    issue_op(2'd0, 1'b0, 2'd0, 2'd0, 2'd2, 1'b1, 1'b0, 1'b0);
    check("collide_accept_gap", last_acc - coll, 1);
    check("collide_alu_a", alu_a, 9);
    drain();

    // Back-to-back with op_valid held high
    d0 = done_cnt;
    issue_op(2'd0, 1'b0, 2'd1, 2'd2, 2'd0, 1'b1, 1'b1, 1'b0);
    a1 = last_acc;
    issue_op(2'd3, 1'b1, 2'd0, 2'd3, 2'd1, 1'b1, 1'b0, 1'b0);
    a2 = last_acc;
    check("b2b_gap", a2 - a1, 3);
    drain();
    check("b2b_done_count", done_cnt - d0, 2);

    // Randomized mix of loads, single ops, paired ops and ignored loads
    for (int it = 0; it < 40; it++) begin
      k    = int'($urandom_range(0, 3));
      r_op = 2'($urandom);
      r_rs = 2'($urandom);
      r_rt = 2'($urandom);
      r_rd = 2'($urandom);
      if (k == 0) begin
        drain();
        do_load(2'($urandom), 4'($urandom));
      end else if (k == 3) begin
        issue_op(r_op, 1'($urandom), r_rs, r_rt, r_rd, 1'($urandom), 1'b1, 1'b0);
        a1 = last_acc;
        issue_op(2'($urandom), 1'($urandom), r_rd, r_rs, r_rt, 1'($urandom), 1'b0, 1'b0);
        check("rnd_b2b_gap", last_acc - a1, 3);
      end else begin
        issue_op(r_op, 1'($urandom), r_rs, r_rt, r_rd, 1'($urandom), 1'b0, 1'($urandom));
      end
    end
    drain();
    for (int i = 0; i < 4; i++) begin
      stim_dbg = 2'(i);
      #1;
      check("rnd_final_reg", dbg_data, mreg[i]);
    end

    // Reset during EXEC abandons the operation
    do_load(2'd1, 4'd6);
    do_load(2'd2, 4'd7);
    issue_op(2'd0, 1'b0, 2'd1, 2'd2, 2'd3, 1'b1, 1'b0, 1'b0);
    d0 = done_cnt;
    apply_reset();
    repeat (5) @(negedge clk);
    #1;
    check("midrst_no_done", done_cnt - d0, 0);
    check_reset_state();

    check("sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_exec_ctrl.md
Name: alu_exec_ctrl

Overview:
- Operand-supply and result-writeback stage wrapped around the 4-bit combinational ALU.
- Holds a 4-entry x 4-bit register bank and a 3-bit flag register.
- Accepts one operation at a time over a valid/ready handshake, drives the ALU's A, B, ALUop and L inputs from registers, and captures R, zero, carry and sign.
- Writes results back into the bank and flag register through a 3-state FSM.

Parameters:
- W, 4, data width; fixed to the ALU width, other values unsupported.
- NREG, 4, register count; address width is 2.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous active-low reset, sampled on the rising edge of clk.
- op_valid  in  1  operation request.
- op_ready  out  1  operation accept.
- op_code  in  2  forwarded to the ALU's ALUop.
- op_l  in  1  forwarded to the ALU's L.
- op_rs  in  2  source register for A.
- op_rt  in  2  source register for B.
- op_rd  in  2  destination register.
- op_we  in  1  when 1, write the result to op_rd.
- load_valid  in  1  direct register write request.
- load_addr  in  2  direct write address.
- load_data  in  4  direct write data.
- alu_a  out  4  ALU operand A.
- alu_b  out  4  ALU operand B.
- alu_op  out  2  ALU operation select.
- alu_l  out  1  ALU L control.
- alu_r  in  4  ALU result.
- alu_zero  in  1  ALU zero flag.
- alu_carry  in  1  ALU carry flag.
- alu_sign  in  1  ALU sign flag.
- flags  out  3  {sign, carry, zero} of the last completed operation.
- done  out  1  one-cycle completion pulse.
- dbg_addr  in  2  debug read address.
- dbg_data  out  4  combinational read of reg[dbg_addr].

Behaviour:
- Reset:
  - Applies when rst_n=0 at a rising edge, in any state.
  - All registers, alu_a, alu_b, alu_op, alu_l, the result/flag capture registers and flags go to 0.
  - FSM goes to IDLE; done=0.
  - Reset mid-operation abandons the operation: no writeback, no done pulse.
- op_ready = (state==IDLE) && !load_valid, combinational.
- IDLE:
  - If load_valid=1: reg[load_addr] <= load_data at the edge. Load wins over op_valid; the op is not accepted and stays pending.
  - Else if op_valid=1: accept the operation at the edge.
    - alu_a <= reg[op_rs], alu_b <= reg[op_rt], alu_op <= op_code, alu_l <= op_l.
    - Latch op_rd and op_we.
    - Go to EXEC.
  - load_valid outside IDLE is ignored and performs no write.
- EXEC:
  - The ALU evaluates combinationally on the registered operands.
  - At the edge: capture alu_r into res, and {alu_sign, alu_carry, alu_zero} into fres. Go to WB.
  - alu_a, alu_b, alu_op and alu_l are held stable through EXEC and WB; they change only on the next accept.
- WB:
  - done=1 for exactly this cycle.
  - At the edge: if the latched we=1, reg[rd] <= res. flags <= fres unconditionally, including when we=0. Go to IDLE.
- Latency and throughput:
  - Accept edge T. done is high in the cycle after edge T+1. Register and flags are updated at edge T+2.
  - Next accept is possible at edge T+3, giving at most one op per 3 cycles.
- Hazards:
  - None. Operands are read at accept, and the prior writeback always completes first.
  - rs==rt==rd is legal.
- dbg_data:
  - Combinational read of reg[dbg_addr].
  - Reflects writes from the cycle after the writing edge.
- op_valid held high while op_ready=0 is legal. The request is accepted at the first IDLE edge without load_valid, using the field values present at that edge.
- Width rules:
  - No arithmetic is performed here; the ALU result is stored unmodified as 4 bits.
  - Flag bit order: flags[2]=sign, flags[1]=carry, flags[0]=zero.

Test Plan:
- Reset: after any activity, hold rst_n=0 for 1 edge -> all dbg_data reads return 0, flags=000, done=0, op_ready=1, alu_a=alu_b=0.
- Basic op, with the bench ALU model returning R=alu_a+alu_b:
  - Stimulus: load R1=3, R2=5; then op rs=1, rt=2, rd=3, we=1.
  - Required: alu_a=3 and alu_b=5 in the cycle after accept; done high 2 cycles after accept; R3=8 and flags=000 after the next edge; op_ready low during EXEC and WB.
- Flags without write:
  - Stimulus: model returns R=0, zero=1, carry=1; op with we=0, rd=1.
  - Required: R1 remains 3; flags=011 after WB.
- Load/op collision:
  - Stimulus: in IDLE, load_valid=1 (addr 0, data 9) and op_valid=1 (rs=0, rt=0, rd=2) together.
  - Required: R0=9 and op_ready=0 that cycle; op accepted next edge with alu_a=alu_b=9; R2 receives the model result.
- Back-to-back: hold op_valid high for 2 ops -> second accept occurs exactly 3 cycles after the first; exactly 2 done pulses.
- Reset mid-operation: assert rst_n=0 during EXEC -> no done, target register stays 0, FSM returns to IDLE.
